store_commit_checker: RTL

- Parametrised, synthesisable successor to the negedge store-watch checker in the 5-stage core bench.
- Snoops the core's data-memory write port (memwrite/dataadr/writedata) and matches each committed store against a programmed table of expected address/data pairs.
- Reports pass/fail/timeout with counters and the captured offending store.
- Sits beside top in simulation and in FPGA self-test wrappers; the bench drives the programming port and reads the status outputs.

---
 rtl/store_commit_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/store_commit_checker.sv
// Store-commit checker: snoops the core's data-memory write port and matches each
// committed store against a programmed table of expected address/data pairs.
module store_commit_checker #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int ORDERED = 1,
   parameter int IW      = $clog2(DEPTH),
   parameter int CW      = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            prog_we,
   input  logic [IW-1:0]   prog_idx,
   input  logic [XLEN-1:0] prog_addr,
   input  logic [XLEN-1:0] prog_data,
   input  logic [IW:0]     prog_len,
   input  logic            start,
   input  logic            memwrite,
   input  logic [XLEN-1:0] dataadr,
   input  logic [XLEN-1:0] writedata,
   output logic            done,
   output logic            pass,
   output logic [1:0]      fail_code,
   output logic [IW:0]     match_idx,
   output logic [CW-1:0]   store_count,
   output logic [CW-1:0]   cycle_count,
   output logic [XLEN-1:0] bad_addr,
   output logic [XLEN-1:0] bad_data
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } state_t;

   localparam logic [IW:0]   LP_DEPTH   = DEPTH[IW:0];
   localparam logic [IW:0]   LP_IDX_ONE = 1;
   localparam logic [CW-1:0] LP_CNT_ONE = 1;
   localparam logic [CW-1:0] LP_TO_LAST = CW'(TIMEOUT - 1);

   state_t            r_state;
   logic [IW:0]       r_len;
   logic              r_done;
   logic              r_pass;
   logic [1:0]        r_fail_code;
   logic [IW:0]       r_match_idx;
   logic [CW-1:0]     r_store_count;
   logic [CW-1:0]     r_cycle_count;
   logic [XLEN-1:0]   r_bad_addr;
   logic [XLEN-1:0]   r_bad_data;

   logic [XLEN-1:0]   r_tab_addr [DEPTH];
   logic [XLEN-1:0]   r_tab_data [DEPTH];

   logic              w_idle;
   logic [IW:0]       w_len;
   logic              w_hit;
   logic              w_last;
   logic              w_timeout;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + LP_CNT_ONE;
   endfunction

   assign w_idle    = (r_state == ST_IDLE);
   assign w_len     = (prog_len > LP_DEPTH) ? LP_DEPTH : prog_len;
   assign w_hit     = (r_tab_addr[r_match_idx[IW-1:0]] == dataadr) &&
                      (r_tab_data[r_match_idx[IW-1:0]] == writedata);
   assign w_last    = ((r_match_idx + LP_IDX_ONE) == r_len);
   assign w_timeout = (r_cycle_count == LP_TO_LAST);

   // NOTE: the table has no reset so it can map to RAM and survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (w_idle && prog_we) begin
         r_tab_addr[prog_idx] <= prog_addr;
         r_tab_data[prog_idx] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_len         <= '0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_fail_code   <= 2'd0;
         r_match_idx   <= '0;
         r_store_count <= '0;
         r_cycle_count <= '0;
         r_bad_addr    <= '0;
         r_bad_data    <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_cycle_count <= sat_inc(r_cycle_count);
               if (memwrite) begin
                  r_store_count <= sat_inc(r_store_count);
               end
               if (memwrite && w_hit) begin
                  r_match_idx <= r_match_idx + LP_IDX_ONE;
               end
               // Exit priority: final hit, then ordered mismatch, then timeout.
               if (memwrite && w_hit && w_last) begin
                  r_state <= ST_PASS;
                  r_done  <= 1'b1;
                  r_pass  <= 1'b1;
               end else if (memwrite && !w_hit && (ORDERED != 0)) begin
                  r_state     <= ST_FAIL;
                  r_done      <= 1'b1;
                  r_fail_code <= 2'd1;
                  r_bad_addr  <= dataadr;
                  r_bad_data  <= writedata;
               end else if (w_timeout) begin
                  r_state     <= ST_TIMEOUT;
                  r_done      <= 1'b1;
                  r_fail_code <= 2'd2;
               end
            end
            default: begin
               // IDLE and the sticky terminal states only react to start.
               if (start) begin
                  r_len         <= w_len;
                  r_fail_code   <= 2'd0;
                  r_match_idx   <= '0;
                  r_store_count <= '0;
                  r_cycle_count <= '0;
                  r_bad_addr    <= '0;
                  r_bad_data    <= '0;
                  if (w_len == '0) begin
                     r_state <= ST_PASS;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_done  <= 1'b0;
                     r_pass  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign done        = r_done;
   assign pass        = r_pass;
   assign fail_code   = r_fail_code;
   assign match_idx   = r_match_idx;
   assign store_count = r_store_count;
   assign cycle_count = r_cycle_count;
   assign bad_addr    = r_bad_addr;
   assign bad_data    = r_bad_data;

endmodule
